// File: rtl/pdm_demodulator.sv
// ---------------------------------------------------------------------------
// pdm_demodulator
//
// Purpose:
//   Receive-side decoder for a first-order sigma-delta (PDM) bitstream.
//   The incoming bit is resynchronised into the clk domain. The block then
//   counts ones over a boxcar window of 2^VALUE_BITS accepted samples. At
//   each window close it publishes the count as the decoded value and pulses
//   valid for one cycle.
//
// Parameters:
//   VALUE_BITS   width of the decoded value; window = 2^VALUE_BITS accepted samples
//   SYNC_STAGES  synchroniser depth in flops; 0 uses pdm_in directly
//
// Ports:
//   clk        in   1           single clock, all logic on posedge
//   rst_n      in   1           asynchronous, active-low reset
//   sample_en  in   1           sample qualifier; synchronised bit accepted when 1
//   pdm_in     in   1           PDM bitstream
//   value      out  VALUE_BITS  decoded value of the last completed window
//   valid      out  1           one-cycle strobe, value updated this cycle
//   saturated  out  1           last window count was clamped to all-ones
// ---------------------------------------------------------------------------
module pdm_demodulator #(
    parameter int VALUE_BITS  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_en,
    input  logic                  pdm_in,
    output logic [VALUE_BITS-1:0] value,
    output logic                  valid,
    output logic                  saturated
);

    // Index of the last sample in a window (all ones in the window counter).
    localparam logic [VALUE_BITS-1:0] LP_WIN_LAST = {VALUE_BITS{1'b1}};
    localparam logic [VALUE_BITS-1:0] LP_ONE      = {{(VALUE_BITS-1){1'b0}}, 1'b1};

    logic                  w_pdm_s;
    logic                  w_last;
    logic [VALUE_BITS:0]   w_sum;

    logic [VALUE_BITS-1:0] r_win_cnt;
    logic [VALUE_BITS:0]   r_ones_cnt;
    logic [VALUE_BITS-1:0] r_value;
    logic                  r_valid;
    logic                  r_saturated;

    // Input synchroniser. It shifts on every clock whether or not sample_en
    // is high. This keeps the delay from pdm_in to the counter fixed at
    // SYNC_STAGES cycles.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_pdm_s = pdm_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= pdm_in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_pdm_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // The ones counter is one bit wider than the value. An all-ones window
    // therefore sums to exactly 2^VALUE_BITS, and its top bit alone marks
    // the clamp case.
    assign w_sum  = r_ones_cnt + {{VALUE_BITS{1'b0}}, w_pdm_s};
    assign w_last = (r_win_cnt == LP_WIN_LAST);

    // Window accumulation and publish. The last sample of a window is folded
    // into the published sum on the same edge that clears the counters. No
    // sample is lost at the boundary, and the next accepted sample begins the
    // new window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_cnt   <= '0;
            r_ones_cnt  <= '0;
            r_value     <= '0;
            r_valid     <= 1'b0;
            r_saturated <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (sample_en) begin
                if (w_last) begin
                    r_win_cnt   <= '0;
                    r_ones_cnt  <= '0;
                    r_value     <= w_sum[VALUE_BITS] ? LP_WIN_LAST : w_sum[VALUE_BITS-1:0];
                    r_saturated <= w_sum[VALUE_BITS];
                    r_valid     <= 1'b1;
                end else begin
                    r_win_cnt  <= r_win_cnt + LP_ONE;
                    r_ones_cnt <= w_sum;
                end
            end
        end
    end

    assign value     = r_value;
    assign valid     = r_valid;
    assign saturated = r_saturated;

endmodule
